special_bypass_pipe: RTL
========================

// Module: special_bypass_pipe
// PURPOSE
//  Carries the special/trivial verdict (tag + posit bits) from operand input conditioning alongside the PPU arithmetic core.
//  Delays it by exactly the core latency, in lockstep with the core.
//  At the tail it muxes the final result: the bypassed special posit when tagged, otherwise the core result.
//  Owns the pipeline valid/ready handshake and the global stall that freezes the core.
// PARAMETERS
//  N           16  posit width in bits
//  PIPE_DEPTH  3   core latency in cycles (>=1); number of bypass stages
// PORTS
//  clk_i          in   1                    clock, all state on rising edge
//  rst_ni         in   1                    synchronous, active-low reset
//  in_valid_i     in   1                    conditioned operands + verdict valid this cycle
//  in_ready_o     out  1                    stage accepts input (== advance)
//  p_special_i    in   posit_special_t      {posit.bits[N-1:0], special_tag} from conditioning
//  core_result_i  in   N                    core output aligned with the tail stage
//  core_stall_o   out  1                    core must hold all pipeline registers
//  out_valid_o    out  1                    result_o valid
//  out_ready_i    in   1                    downstream accepts result
//  result_o       out  N                    final posit result
//  special_o      out  1                    result came from the bypass (debug/perf)
//  occupancy_o    out  $clog2(PIPE_DEPTH+1) number of valid stages
// BEHAVIOUR
//  - State: per stage k (0..PIPE_DEPTH-1): vld[k], tag[k], bits[k][N-1:0]. Stage 0 is the head; PIPE_DEPTH-1 is the tail.
//  - advance = ~vld[PIPE_DEPTH-1] | out_ready_i. This is a global stall with no bubble collapse, so the core stays in lockstep.
//  - in_ready_o = advance; core_stall_o = ~advance.
//  - When advance: stage 0 loads {in_valid_i, p_special_i}, stage k loads stage k-1. When ~advance: all stages hold.
//  - Accepted input appears at the tail exactly PIPE_DEPTH advancing cycles later.
//  - Input is captured even when in_valid_i is low. vld=0 marks a bubble; tag/bits of a bubble are don't-care but still registered.
//  - out_valid_o = vld[tail].
//  - result_o = tag[tail] ? bits[tail] : core_result_i (combinational mux); special_o = vld[tail] & tag[tail].
//  - Output hold: while out_valid_o & ~out_ready_i, result_o, special_o and the tail stage are stable.
//    The core is frozen, so core_result_i is stable too.
//  - occupancy_o = popcount(vld). It is a registered counter:
//    +1 on (advance & in_valid_i), -1 on (out_valid_o & out_ready_i), unchanged when both occur.
//    It must always equal popcount(vld) (assertion).
//  - Reset (rst_ni=0 at a clock edge):
//    - All vld cleared; tag/bits cleared to 0; occupancy_o=0.
//    - Outputs then read out_valid_o=0, special_o=0, in_ready_o=1, core_stall_o=0.
//    - result_o then reads core_result_i, since tag=0.
//  - Reset mid-operation discards all in-flight entries; no partial result is emitted.
//  - Full pipe (occupancy==PIPE_DEPTH) with out_ready_i=1: accept and retire in the same cycle, no bubble.
//  - Full pipe with out_ready_i=0: in_ready_o=0, and an input offered while in_valid_i=1 is not taken.
//    Upstream must hold its data.
//  - Empty tail (out_valid_o=0): the pipe always advances regardless of out_ready_i.
//  - The F2P operation never tags: the upstream verdict arrives with tag=0 and the core result is selected. This block does not decode op.
// STRUCTURE
//  - Shared package ppu_pkg holds: posit_t, posit_special_t, ZERO ('0), NAR (1<<(N-1)), and a PIPE_DEPTH default constant shared with the core.
//  - One natural sub-module: bypass_stage (one {vld,tag,bits} register with enable and sync active-low clear), generated PIPE_DEPTH times.
//  - Tail mux and occupancy counter live in the top.
// TESTING (N=16, PIPE_DEPTH=3)
//  - Reset: hold rst_ni=0 for 2 cycles with garbage inputs
//    -> out_valid_o=0, occupancy_o=0, in_ready_o=1, special_o=0.
//  - Bypass: inject tag=1, bits=16'h8000 (NaR), out_ready_i=1
//    -> exactly 3 cycles later out_valid_o=1, result_o=16'h8000, special_o=1.
//  - Core path: inject tag=0 and drive core_result_i=16'h4800 at the tail cycle
//    -> result_o=16'h4800, special_o=0.
//  - Back-to-back mix: stream tag 1,0,1 with bits 0x0000,x,0x8000 every cycle
//    -> results 0x0000, core value, 0x8000 on consecutive cycles; occupancy_o reaches 3.
//  - Backpressure: fill 3 entries, hold out_ready_i=0 for 5 cycles
//    -> in_ready_o=0, core_stall_o=1, result_o stable.
//    Then release -> drains in order with no loss or duplication.
//  - Mid-flight reset: 2 entries in flight, pulse rst_ni=0 for 1 cycle
//    -> no out_valid_o for the next 3 cycles, occupancy_o=0.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared posit types and constants for the PPU datapath.
// Used by the conditioning logic, the arithmetic core and the bypass pipe.
package ppu_pkg;

  localparam int unsigned POSIT_W        = 16;
  localparam int unsigned PIPE_DEPTH_DEF = 3;

  typedef struct packed {
    logic [POSIT_W-1:0] bits;
  } posit_t;

  typedef struct packed {
    posit_t posit;
    logic   special_tag;
  } posit_special_t;

  localparam posit_t ZERO = '0;
  localparam posit_t NAR  = '{bits: {1'b1, {(POSIT_W-1){1'b0}}}};

  function automatic logic is_nar(input posit_t p);
    return p == NAR;
  endfunction

endpackage

// File: rtl/bypass_stage.sv
// One bypass pipeline register: {vld, tag, bits} with load enable.
// Ports: clk, rst_n (sync, active-low), en, d_* in, q_* out.
module bypass_stage #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         d_vld,
  input  logic         d_tag,
  input  logic [W-1:0] d_bits,
  output logic         q_vld,
  output logic         q_tag,
  output logic [W-1:0] q_bits
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_vld  <= 1'b0;
      q_tag  <= 1'b0;
      q_bits <= '0;
    end else if (en) begin
      q_vld  <= d_vld;
      q_tag  <= d_tag;
      q_bits <= d_bits;
    end
  end

endmodule

// File: rtl/special_bypass_pipe.sv
// Delays the special-case verdict in lockstep with the PPU core and
// picks bypass vs core result at the tail; owns handshake and stall.
// Ports: clk_i, rst_ni, in_valid_i/in_ready_o, p_special_i,
//   core_result_i, core_stall_o, out_valid_o/out_ready_i,
//   result_o, special_o, occupancy_o.
module special_bypass_pipe
  import ppu_pkg::*;
#(
  parameter int unsigned N          = POSIT_W,
  parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF,
  localparam int unsigned OW        = $clog2(PIPE_DEPTH + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  posit_special_t p_special_i,
  input  logic [N-1:0]   core_result_i,
  output logic           core_stall_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [N-1:0]   result_o,
  output logic           special_o,
  output logic [OW-1:0]  occupancy_o
);

  localparam int unsigned T = PIPE_DEPTH - 1;

  logic [PIPE_DEPTH-1:0] vld;
  logic [PIPE_DEPTH-1:0] tag;
  logic [N-1:0]          bits [PIPE_DEPTH];
  logic                  advance;
  logic                  inc;
  logic                  dec;

  // Global stall: every stage moves together so the core stays aligned.
  assign advance      = ~vld[T] | out_ready_i;
  assign in_ready_o   = advance;
  assign core_stall_o = ~advance;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      bypass_stage #(.W(N)) u_stage (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .en     (advance),
        .d_vld  (in_valid_i),
        .d_tag  (p_special_i.special_tag),
        .d_bits (N'(p_special_i.posit.bits)),
        .q_vld  (vld[k]),
        .q_tag  (tag[k]),
        .q_bits (bits[k])
      );
    end else begin : g_body
      bypass_stage #(.W(N)) u_stage (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .en     (advance),
        .d_vld  (vld[k-1]),
        .d_tag  (tag[k-1]),
        .d_bits (bits[k-1]),
        .q_vld  (vld[k]),
        .q_tag  (tag[k]),
        .q_bits (bits[k])
      );
    end
  end

  assign out_valid_o = vld[T];
  assign result_o    = tag[T] ? bits[T] : core_result_i;
  assign special_o   = vld[T] & tag[T];

  assign inc = advance & in_valid_i;
  assign dec = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      occupancy_o <= '0;
    end else if (inc & ~dec) begin
      occupancy_o <= occupancy_o + OW'(1);
    end else if (dec & ~inc) begin
      occupancy_o <= occupancy_o - OW'(1);
    end
  end

  occ_matches_vld: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    occupancy_o == OW'($countones(vld))
  );

endmodule
